// File: rtl/bullet_ctrl.sv
// Two-player shooter bullet controller: one bullet per player, frame-tick paced
// movement, hit/guard resolution, HP bookkeeping and IDLE/PLAY/OVER game phase.
module bullet_ctrl #(
  parameter int BULLET_STEP = 12,
  parameter int HP_WIDTH    = 3,
  parameter int HP_INIT     = 5,
  parameter int SPAWN_OFS   = 32,
  parameter int X_MIN       = -640,
  parameter int X_MAX       = 639
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_tick,
  input  logic                i_start,
  input  logic                i_fire1,
  input  logic                i_fire2,
  input  logic signed [11:0]  i_p1_x,
  input  logic signed [11:0]  i_p2_x,
  input  logic                i_p1_guard,
  input  logic                i_p2_guard,
  output logic [1:0]          o_phase,
  output logic                o_b1_valid,
  output logic                o_b2_valid,
  output logic signed [11:0]  o_b1_x,
  output logic signed [11:0]  o_b2_x,
  output logic [HP_WIDTH-1:0] o_hp1,
  output logic [HP_WIDTH-1:0] o_hp2,
  output logic                o_hit1,
  output logic                o_hit2,
  output logic [1:0]          o_winner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } phase_t;

  localparam logic signed [12:0] STEP13  = 13'(BULLET_STEP);
  localparam logic signed [12:0] SPAWN13 = 13'(SPAWN_OFS);
  localparam logic signed [12:0] XMIN13  = 13'(X_MIN);
  localparam logic signed [12:0] XMAX13  = 13'(X_MAX);
  localparam logic [HP_WIDTH-1:0] HP_LOAD = HP_WIDTH'(HP_INIT);
  localparam logic [HP_WIDTH-1:0] HP_ONE  = HP_WIDTH'(1);

  phase_t phase;
  logic   fire1_latch, fire2_latch;

  // All position arithmetic is 13-bit signed so +/- a step never wraps.
  logic signed [12:0] p1_13, p2_13, b1_13, b2_13;
  logic signed [12:0] b1_nx, b2_nx, b1_sp, b2_sp;
  logic               b1_hit, b2_hit, b1_out, b2_out;
  logic               dmg1, dmg2, fire1_req, fire2_req;
  logic [HP_WIDTH-1:0] hp1_nx, hp2_nx;
  logic               hp1_zero, hp2_zero;

  assign p1_13 = $signed({i_p1_x[11], i_p1_x});
  assign p2_13 = $signed({i_p2_x[11], i_p2_x});
  assign b1_13 = $signed({o_b1_x[11], o_b1_x});
  assign b2_13 = $signed({o_b2_x[11], o_b2_x});

  assign b1_nx = b1_13 + STEP13;
  assign b2_nx = b2_13 - STEP13;
  assign b1_sp = p1_13 + SPAWN13;
  assign b2_sp = p2_13 - SPAWN13;

  assign b1_hit = (b1_nx >= p2_13);
  assign b2_hit = (b2_nx <= p1_13);
  assign b1_out = (b1_nx > XMAX13);
  assign b2_out = (b2_nx < XMIN13);

  // A guarded target still absorbs (retires) the bullet, it just takes no damage.
  assign dmg2 = o_b1_valid & b1_hit & ~i_p2_guard;
  assign dmg1 = o_b2_valid & b2_hit & ~i_p1_guard;

  assign hp1_nx = (dmg1 && (o_hp1 != '0)) ? (o_hp1 - HP_ONE) : o_hp1;
  assign hp2_nx = (dmg2 && (o_hp2 != '0)) ? (o_hp2 - HP_ONE) : o_hp2;
  assign hp1_zero = (hp1_nx == '0);
  assign hp2_zero = (hp2_nx == '0);

  assign fire1_req = fire1_latch | i_fire1;
  assign fire2_req = fire2_latch | i_fire2;

  assign o_phase = phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase       <= IDLE;
      o_b1_valid  <= 1'b0;
      o_b2_valid  <= 1'b0;
      o_b1_x      <= '0;
      o_b2_x      <= '0;
      o_hp1       <= HP_LOAD;
      o_hp2       <= HP_LOAD;
      o_hit1      <= 1'b0;
      o_hit2      <= 1'b0;
      o_winner    <= 2'b00;
      fire1_latch <= 1'b0;
      fire2_latch <= 1'b0;
    end else begin
      o_hit1 <= 1'b0;
      o_hit2 <= 1'b0;
      case (phase)
        IDLE: begin
          if (i_start) begin
            phase       <= PLAY;
            o_hp1       <= HP_LOAD;
            o_hp2       <= HP_LOAD;
            o_b1_valid  <= 1'b0;
            o_b2_valid  <= 1'b0;
            fire1_latch <= 1'b0;
            fire2_latch <= 1'b0;
            o_winner    <= 2'b00;
          end
        end
        PLAY: begin
          if (i_frame_tick) begin
            fire1_latch <= 1'b0;
            fire2_latch <= 1'b0;
            o_hit1      <= dmg1;
            o_hit2      <= dmg2;
            o_hp1       <= hp1_nx;
            o_hp2       <= hp2_nx;
            if (hp1_zero || hp2_zero) begin
              phase      <= OVER;
              o_winner   <= {hp1_zero, hp2_zero};
              o_b1_valid <= 1'b0;
              o_b2_valid <= 1'b0;
            end else begin
              // An in-flight bullet swallows its fire request; retiring never respawns.
              if (o_b1_valid) begin
                if (b1_hit || b1_out) o_b1_valid <= 1'b0;
                else                  o_b1_x     <= b1_nx[11:0];
              end else if (fire1_req) begin
                o_b1_valid <= 1'b1;
                o_b1_x     <= b1_sp[11:0];
              end
              if (o_b2_valid) begin
                if (b2_hit || b2_out) o_b2_valid <= 1'b0;
                else                  o_b2_x     <= b2_nx[11:0];
              end else if (fire2_req) begin
                o_b2_valid <= 1'b1;
                o_b2_x     <= b2_sp[11:0];
              end
            end
          end else begin
            fire1_latch <= fire1_latch | i_fire1;
            fire2_latch <= fire2_latch | i_fire2;
          end
        end
        OVER: begin
          if (i_start) begin
            phase    <= IDLE;
            o_winner <= 2'b00;
          end
        end
        default: phase <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: directed game scenarios with literal expectations, then
// random play checked every cycle against an integer game model.
module tb_bullet_ctrl;

  localparam int STEP    = 12;
  localparam int HPW     = 3;
  localparam int HP_INIT = 5;
  localparam int SPAWN   = 32;
  localparam int X_MIN   = -640;
  localparam int X_MAX   = 639;

  logic              clk, rst_n, tick, start, fire1, fire2, g1, g2;
  logic signed [11:0] p1_x, p2_x;
  logic [1:0]        phase, winner;
  logic              b1_v, b2_v, hit1, hit2;
  logic signed [11:0] b1_x, b2_x;
  logic [HPW-1:0]    hp1, hp2;

  int total = 0;
  int bad   = 0;

  bullet_ctrl #(
    .BULLET_STEP(STEP), .HP_WIDTH(HPW), .HP_INIT(HP_INIT),
    .SPAWN_OFS(SPAWN), .X_MIN(X_MIN), .X_MAX(X_MAX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_start(start),
    .i_fire1(fire1), .i_fire2(fire2), .i_p1_x(p1_x), .i_p2_x(p2_x),
    .i_p1_guard(g1), .i_p2_guard(g2), .o_phase(phase),
    .o_b1_valid(b1_v), .o_b2_valid(b2_v), .o_b1_x(b1_x), .o_b2_x(b2_x),
    .o_hp1(hp1), .o_hp2(hp2), .o_hit1(hit1), .o_hit2(hit2), .o_winner(winner)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrap12(input int v);
    logic signed [11:0] t;
    t = v[11:0];
    return int'(t);
  endfunction

  // ---------------- behavioural game model ----------------
  int m_phase = 0, m_v1 = 0, m_v2 = 0, m_x1 = 0, m_x2 = 0;
  int m_hp1 = HP_INIT, m_hp2 = HP_INIT, m_h1 = 0, m_h2 = 0, m_win = 0;
  int m_l1 = 0, m_l2 = 0;
  int nx, ip1, ip2;

  initial begin
    forever begin
      @(posedge clk);
      ip1 = int'(p1_x);
      ip2 = int'(p2_x);
      if (!rst_n) begin
        m_phase = 0; m_v1 = 0; m_v2 = 0; m_x1 = 0; m_x2 = 0;
        m_hp1 = HP_INIT; m_hp2 = HP_INIT; m_h1 = 0; m_h2 = 0;
        m_win = 0; m_l1 = 0; m_l2 = 0;
      end else begin
        m_h1 = 0; m_h2 = 0;
        if (m_phase == 0) begin
          if (start) begin
            m_phase = 1; m_hp1 = HP_INIT; m_hp2 = HP_INIT;
            m_v1 = 0; m_v2 = 0; m_l1 = 0; m_l2 = 0; m_win = 0;
          end
        end else if (m_phase == 1) begin
          if (tick) begin
            if (m_v1 != 0) begin
              nx = m_x1 + STEP;
              if (nx >= ip2) begin
                m_v1 = 0;
                if (!g2) begin m_h2 = 1; if (m_hp2 > 0) m_hp2--; end
              end else if (nx > X_MAX) m_v1 = 0;
              else m_x1 = nx;
            end else if (m_l1 != 0 || fire1) begin
              m_v1 = 1; m_x1 = wrap12(ip1 + SPAWN);
            end
            if (m_v2 != 0) begin
              nx = m_x2 - STEP;
              if (nx <= ip1) begin
                m_v2 = 0;
                if (!g1) begin m_h1 = 1; if (m_hp1 > 0) m_hp1--; end
              end else if (nx < X_MIN) m_v2 = 0;
              else m_x2 = nx;
            end else if (m_l2 != 0 || fire2) begin
              m_v2 = 1; m_x2 = wrap12(ip2 - SPAWN);
            end
            m_l1 = 0; m_l2 = 0;
            if (m_hp1 == 0 || m_hp2 == 0) begin
              m_phase = 2; m_v1 = 0; m_v2 = 0;
              m_win = (m_hp1 == 0 && m_hp2 == 0) ? 3 : (m_hp2 == 0) ? 1 : 2;
            end
          end else begin
            if (fire1) m_l1 = 1;
            if (fire2) m_l2 = 1;
          end
        end else begin
          if (start) begin m_phase = 0; m_win = 0; end
        end
      end
      #1;
      check("cmp_phase", int'(phase), m_phase);
      check("cmp_b1_valid", int'(b1_v), m_v1);
      check("cmp_b2_valid", int'(b2_v), m_v2);
      if (m_v1 != 0) check("cmp_b1_x", int'(b1_x), m_x1);
      if (m_v2 != 0) check("cmp_b2_x", int'(b2_x), m_x2);
      check("cmp_hp1", int'(hp1), m_hp1);
      check("cmp_hp2", int'(hp2), m_hp2);
      check("cmp_hit1", int'(hit1), m_h1);
      check("cmp_hit2", int'(hit2), m_h2);
      check("cmp_winner", int'(winner), m_win);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_fire(input bit a, input bit b);
    fire1 = a; fire2 = b; @(negedge clk); fire1 = 1'b0; fire2 = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; @(negedge clk); tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int n;

  initial begin
    rst_n = 1'b0; tick = 0; start = 0; fire1 = 0; fire2 = 0; g1 = 0; g2 = 0;
    p1_x = 12'sd0; p2_x = 12'sd100;
    repeat (2) step();
    check("rst_phase", int'(phase), 0);
    check("rst_hp1", int'(hp1), HP_INIT);
    check("rst_b1_x", int'(b1_x), 0);
    rst_n = 1'b1;
    step();

    // basic flight and damaging hit
    pulse_start();
    check("start_phase", int'(phase), 1);
    pulse_fire(1, 0);
    do_tick();
    check("spawn_b1_valid", int'(b1_v), 1);
    check("spawn_b1_x", int'(b1_x), 32);
    check("model_spawn_x", m_x1, 32);
    do_tick(); check("b1_x_44", int'(b1_x), 44);
    do_tick(); check("b1_x_56", int'(b1_x), 56);
    repeat (3) do_tick();
    check("b1_x_92", int'(b1_x), 92);
    do_tick();
    check("hit_hit2", int'(hit2), 1);
    check("hit_hp2", int'(hp2), 4);
    check("hit_b1_retired", int'(b1_v), 0);
    check("model_hp2", m_hp2, 4);
    step();
    check("hit2_one_cycle", int'(hit2), 0);

    // start ignored during play
    pulse_start();
    check("start_ignored_phase", int'(phase), 1);
    check("start_ignored_hp2", int'(hp2), 4);

    // asynchronous reset mid-flight
    pulse_fire(1, 1);
    do_tick();
    check("pre_rst_b1_valid", int'(b1_v), 1);
    rst_n = 1'b0;
    #1;
    check("arst_phase", int'(phase), 0);
    check("arst_b1_valid", int'(b1_v), 0);
    check("arst_b2_valid", int'(b2_v), 0);
    check("arst_hp2", int'(hp2), HP_INIT);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_phase", int'(phase), 0);
    pulse_start();
    do_tick();
    check("no_pending_fire", int'(b1_v), 0);

    // guarded hit retires without damage
    pulse_fire(1, 0);
    repeat (6) do_tick();
    g2 = 1'b1;
    do_tick();
    g2 = 1'b0;
    check("guard_b1_retired", int'(b1_v), 0);
    check("guard_hp2", int'(hp2), 5);
    check("guard_no_hit2", int'(hit2), 0);

    // repeated fire while in flight is dropped; exit past X_MAX
    p2_x = 12'sd2000;
    pulse_fire(1, 0);
    do_tick();
    repeat (3) begin pulse_fire(1, 0); step(); end
    do_tick();
    check("busy_b1_valid", int'(b1_v), 1);
    check("busy_b1_x", int'(b1_x), 44);
    n = 0;
    while (b1_v && n < 60) begin do_tick(); n++; end
    check("exit_ticks", n, 50);
    check("exit_b1_valid", int'(b1_v), 0);
    do_tick();
    check("dropped_fire", int'(b1_v), 0);
    pulse_fire(1, 0);
    do_tick();
    check("refire_b1_x", int'(b1_x), 32);
    do_tick();
    check("refire_single", int'(b1_x), 44);

    // simultaneous killing hits -> draw
    p2_x = 12'sd100;
    do_reset();
    pulse_start();
    for (int r = 0; r < 5; r++) begin
      pulse_fire(1, 1);
      repeat (7) do_tick();
      if (r == 3) begin
        check("pre_draw_hp1", int'(hp1), 1);
        check("pre_draw_hp2", int'(hp2), 1);
      end
    end
    check("draw_phase", int'(phase), 2);
    check("draw_winner", int'(winner), 3);
    check("draw_hit1", int'(hit1), 1);
    check("draw_hit2", int'(hit2), 1);
    step();
    check("draw_hit1_clear", int'(hit1), 0);
    check("draw_b2_cleared", int'(b2_v), 0);
    check("draw_winner_hold", int'(winner), 3);
    pulse_start();
    check("over_to_idle", int'(phase), 0);
    check("idle_winner", int'(winner), 0);
    check("idle_hp_hold", int'(hp1), 0);

    // random play
    for (int i = 0; i < 8000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      start = ($urandom_range(0, 11) == 0);
      tick  = ($urandom_range(0, 3) == 0);
      fire1 = ($urandom_range(0, 5) == 0);
      fire2 = ($urandom_range(0, 5) == 0);
      g1    = ($urandom_range(0, 2) == 0);
      g2    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 31) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          p1_x = 12'(-int'($urandom_range(0, 650)));
          p2_x = 12'($urandom_range(0, 650));
        end else begin
          p1_x = 12'(-int'($urandom_range(0, 100)));
          p2_x = 12'($urandom_range(0, 100));
        end
      end
      step();
    end
    rst_n = 1'b1; start = 0; tick = 0; fire1 = 0; fire2 = 0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
